// File: rtl/rx_readback_dmac.sv
// rx_readback_dmac
//   Drains finished packets from the DDR ring buffer through an AXI4 read
//   master and forwards them as a 128-bit AXI-Stream toward the USB/host side.
//   After each complete packet, buffer_packet_tick is handshaked with the
//   write DMA so that it can release the packet's space.
//
// Ports
//   aclk, aresetn              clock, async active-low reset
//   read_enable                keep the read loop running
//   buffer_base_address/size   ring location and size (bytes)
//   buffer_packet_size_bytes   bytes per packet (multiple of burst bytes)
//   burst_length_set           beats per AXI burst, 1..256
//   buffer_empty               write DMA holds less than one packet
//   buffer_packet_tick(_ack)   packet-consumed strobe / level ack
//   read_state, read_error,
//   packet_count, read_address status
//   m_axi_ar*/m_axi_r*         AXI4 read address / data channels
//   m_axis_tx_*                AXI-Stream output, tlast on packet end
//
// state | meaning
// ------+---------------------------------------------------------------
//   0   | IDLE : counters and address reload, error clears
//   1   | WAIT : wait for a stored packet (buffer_empty=0)
//   2   | AR   : present burst address until arready
//   3   | R    : stream read beats straight through to the AXI-Stream port
//   4   | TICK : packet-consumed handshake with the write DMA
module rx_readback_dmac #(
  parameter int ADDR_W = 48,
  parameter int DATA_W = 128
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] buffer_base_address,
  input  logic [31:0]       buffer_size,
  input  logic [16:0]       buffer_packet_size_bytes,
  input  logic [8:0]        burst_length_set,
  input  logic              buffer_empty,
  output logic              buffer_packet_tick,
  input  logic              buffer_packet_tick_ack,
  output logic [2:0]        read_state,
  output logic              read_error,
  output logic [31:0]       packet_count,
  output logic [31:0]       read_address,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] m_axis_tx_tdata,
  output logic              m_axis_tx_tvalid,
  input  logic              m_axis_tx_tready,
  output logic              m_axis_tx_tlast
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_AR   = 3'd2;
  localparam logic [2:0] S_R    = 3'd3;
  localparam logic [2:0] S_TICK = 3'd4;

  // TICK sub-phases: a stale ack must be seen low before the strobe rises
  localparam logic [1:0] T_PRE  = 2'd0;
  localparam logic [1:0] T_HIGH = 2'd1;
  localparam logic [1:0] T_POST = 2'd2;

  logic [2:0]        state_q, state_d;
  logic [1:0]        tph_q, tph_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [16:0]       burst_cnt_q, burst_cnt_d;
  logic [16:0]       bpp_q, bpp_d;
  logic              read_error_q, read_error_d;
  logic [31:0]       packet_count_q, packet_count_d;

  logic [ADDR_W-1:0] burst_bytes;
  logic [ADDR_W-1:0] offset_next;
  logic [16:0]       bpp_calc;
  logic              in_r;
  logic              beat;
  logic              last_burst;
  logic              wrap;
  logic              err_now;
  logic              unused_rresp0;

  assign unused_rresp0 = m_axi_rresp[0];

  assign burst_bytes = ADDR_W'({burst_length_set, 4'b0000});
  assign bpp_calc    = buffer_packet_size_bytes / 17'({burst_length_set, 4'b0000});

  // The ring is tracked as an offset from base so that reset and IDLE
  // reload to the base address without needing a non-constant reset value.
  assign offset_next = offset_q + burst_bytes;
  assign wrap        = offset_next >= ADDR_W'(buffer_size);

  assign in_r       = (state_q == S_R);
  assign beat       = in_r & m_axi_rvalid & m_axis_tx_tready;
  assign last_burst = (burst_cnt_q == bpp_q - 17'd1);
  assign err_now    = read_error_q | (beat & m_axi_rresp[1]);

  always_comb begin
    state_d        = state_q;
    tph_d          = tph_q;
    offset_d       = offset_q;
    burst_cnt_d    = burst_cnt_q;
    bpp_d          = bpp_q;
    read_error_d   = read_error_q;
    packet_count_d = packet_count_q;

    case (state_q)
      S_IDLE: begin
        burst_cnt_d  = '0;
        offset_d     = '0;
        read_error_d = 1'b0;
        tph_d        = T_PRE;
        if (!read_enable) begin
          packet_count_d = '0;
        end else begin
          bpp_d   = bpp_calc;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (!read_enable) begin
          state_d = S_IDLE;
        end else if (!buffer_empty) begin
          state_d = S_AR;
        end
      end

      S_AR: begin
        if (m_axi_arready) begin
          state_d = S_R;
        end
      end

      S_R: begin
        if (beat && m_axi_rresp[1]) begin
          read_error_d = 1'b1;
        end
        if (beat && m_axi_rlast) begin
          offset_d = wrap ? '0 : offset_next;
          if (err_now) begin
            // errored packet is abandoned; no tick so the write DMA keeps it
            state_d = S_IDLE;
          end else if (!last_burst) begin
            burst_cnt_d = burst_cnt_q + 17'd1;
            state_d     = S_AR;
          end else begin
            burst_cnt_d = '0;
            tph_d       = T_PRE;
            state_d     = S_TICK;
          end
        end
      end

      S_TICK: begin
        case (tph_q)
          T_PRE: begin
            if (!buffer_packet_tick_ack) tph_d = T_HIGH;
          end
          T_HIGH: begin
            if (buffer_packet_tick_ack) tph_d = T_POST;
          end
          default: begin
            if (!buffer_packet_tick_ack) begin
              packet_count_d = packet_count_q + 32'd1;
              tph_d          = T_PRE;
              state_d        = read_enable ? S_WAIT : S_IDLE;
            end
          end
        endcase
      end

      default: begin
        state_d        = S_IDLE;
        tph_d          = T_PRE;
        offset_d       = '0;
        burst_cnt_d    = '0;
        read_error_d   = 1'b0;
        packet_count_d = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= S_IDLE;
      tph_q          <= T_PRE;
      offset_q       <= '0;
      burst_cnt_q    <= '0;
      bpp_q          <= '0;
      read_error_q   <= 1'b0;
      packet_count_q <= '0;
    end else begin
      state_q        <= state_d;
      tph_q          <= tph_d;
      offset_q       <= offset_d;
      burst_cnt_q    <= burst_cnt_d;
      bpp_q          <= bpp_d;
      read_error_q   <= read_error_d;
      packet_count_q <= packet_count_d;
    end
  end

  assign m_axi_araddr  = buffer_base_address + offset_q;
  assign m_axi_arlen   = burst_length_set[7:0] - 8'd1;
  assign m_axi_arvalid = (state_q == S_AR);
  assign m_axi_rready  = in_r & m_axis_tx_tready;

  assign m_axis_tx_tvalid = in_r & m_axi_rvalid;
  assign m_axis_tx_tdata  = in_r ? m_axi_rdata : '0;
  assign m_axis_tx_tlast  = in_r & m_axi_rlast & last_burst;

  assign buffer_packet_tick = (state_q == S_TICK) && (tph_q == T_HIGH);

  assign read_state   = state_q;
  assign read_error   = read_error_q;
  assign packet_count = packet_count_q;
  assign read_address = m_axi_araddr[31:0];

endmodule

// File: tb/tb_rx_readback_dmac.sv
module tb_rx_readback_dmac;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          read_enable = 1'b0;
  logic [47:0]   cfg_base = 48'h0000_1000_0000;
  logic [31:0]   cfg_size = 32'h4000;
  logic [16:0]   cfg_pkt = 17'h1000;
  logic [8:0]    cfg_burst = 9'd16;
  logic          buffer_empty = 1'b1;
  logic          tick;
  logic          ack = 1'b0;
  logic [2:0]    read_state;
  logic          read_error;
  logic [31:0]   packet_count;
  logic [31:0]   read_address;
  logic [47:0]   araddr;
  logic [7:0]    arlen;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [127:0]  rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic          rlast = 1'b0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [127:0]  tdata;
  logic          tvalid;
  logic          tready = 1'b1;
  logic          tlast;

  always #5 aclk = ~aclk;

  rx_readback_dmac dut (
    .aclk(aclk), .aresetn(aresetn), .read_enable(read_enable),
    .buffer_base_address(cfg_base), .buffer_size(cfg_size),
    .buffer_packet_size_bytes(cfg_pkt), .burst_length_set(cfg_burst),
    .buffer_empty(buffer_empty), .buffer_packet_tick(tick),
    .buffer_packet_tick_ack(ack), .read_state(read_state),
    .read_error(read_error), .packet_count(packet_count),
    .read_address(read_address), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready), .m_axis_tx_tdata(tdata), .m_axis_tx_tvalid(tvalid),
    .m_axis_tx_tready(tready), .m_axis_tx_tlast(tlast)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] beat_data(input logic [47:0] a, input int j);
    return {a, 16'h5A5A, 32'(j), 32'hC0DE_0000 ^ a[31:0]};
  endfunction

  // ---------------- slave, sink and write-DMA model ----------------
  int          cyc = 0;
  bit          tog = 0;
  bit          slow = 0;
  bit          force_ack = 0;
  int          avail = 0;
  int          err_at = -1;
  int          ar_cnt = 0, beat_cnt = 0, tlast_cnt = 0, tick_cnt = 0, pkt_beat = 0;
  int          check_idx = -1;
  logic [47:0] check_addr = '0;
  logic [47:0] exp_addr = '0;
  logic [47:0] cur_addr = '0;
  int          burst_len = 0, beat_i = 0;
  bit          burst_active = 0;
  bit          tick_prev = 0;
  bit          p_ar = 0, p_r = 0;
  logic [47:0] p_araddr;
  logic [7:0]  p_arlen;
  logic [127:0] p_tdata;
  logic        p_tlast;

  always begin
    @(negedge aclk);
    cyc++;
    if (!aresetn) begin
      burst_active = 0;
      tick_prev = 0;
    end else begin
      if (p_ar) begin
        check("ar_single_outstanding", burst_active, 0);
        check("araddr", p_araddr, exp_addr);
        if (ar_cnt == check_idx) check("araddr_at_index", p_araddr, check_addr);
        check("arlen", p_arlen, 8'(cfg_burst - 9'd1));
        cur_addr = p_araddr;
        burst_len = int'(p_arlen) + 1;
        beat_i = 0;
        burst_active = 1;
        ar_cnt++;
        exp_addr = exp_addr + {35'd0, cfg_burst, 4'd0};
        if (exp_addr >= cfg_base + {16'd0, cfg_size}) exp_addr = cfg_base;
      end
      if (p_r) begin
        check("tdata", p_tdata, beat_data(cur_addr, beat_i));
        check("tlast", p_tlast, pkt_beat == int'(cfg_pkt >> 4) - 1);
        if (p_tlast) tlast_cnt++;
        pkt_beat = (pkt_beat == int'(cfg_pkt >> 4) - 1) ? 0 : pkt_beat + 1;
        beat_cnt++;
        beat_i++;
        if (beat_i == burst_len) burst_active = 0;
      end
    end
    if (tick && !tick_prev) begin
      tick_cnt++;
      if (avail > 0) avail--;
    end
    tick_prev = tick;
    ack = force_ack | tick_prev;
    buffer_empty = (avail == 0);
    arready = slow ? (cyc % 3 == 0) : 1'b1;
    rvalid = burst_active && (!slow || (cyc % 4 != 1));
    rdata = burst_active ? beat_data(cur_addr, beat_i) : '0;
    rlast = burst_active && (beat_i == burst_len - 1);
    rresp = (burst_active && beat_cnt == err_at) ? 2'b10 : 2'b00;
    tready = tog ? 1'(cyc % 2) : 1'b1;
    #1;
    if (aresetn && read_state == 3'd3) check("rready_mirrors_tready", rready, tready);
    p_ar = aresetn && arvalid && arready;
    p_r = aresetn && rvalid && rready;
    p_araddr = araddr;
    p_arlen = arlen;
    p_tdata = tdata;
    p_tlast = tlast;
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge aclk);
    #2;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string name);
    int n = 0;
    while (read_state !== s && n < max) begin step(); n++; end
    check(name, read_state, s);
  endtask

  task automatic wait_ticks(input int k, input int max, input string name);
    int n = 0;
    while (tick_cnt < k && n < max) begin step(); n++; end
    check(name, tick_cnt, k);
  endtask

  task automatic apply_reset();
    read_enable = 0;
    aresetn = 0;
    step();
    step();
    aresetn = 1;
    ar_cnt = 0; beat_cnt = 0; tlast_cnt = 0; tick_cnt = 0; pkt_beat = 0;
    exp_addr = cfg_base;
    err_at = -1;
    check_idx = -1;
    force_ack = 0;
    step();
  endtask

  task automatic setup(input logic [47:0] b, input logic [31:0] s, input logic [16:0] p,
                       input logic [8:0] bl);
    cfg_base = b; cfg_size = s; cfg_pkt = p; cfg_burst = bl;
    tog = 0; slow = 0; avail = 0;
    apply_reset();
  endtask

  typedef struct {
    logic [47:0] base;
    logic [31:0] size;
    logic [16:0] pkt;
    logic [8:0]  burst;
    int          npk;
    bit          tog;
    bit          slow;
    int          exp_ars;
    int          exp_beats;
    int          chk_idx;
    logic [47:0] chk_addr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{48'h0000_1000_0000, 32'h4000, 17'h1000, 9'd16, 1, 0, 0, 16,   256,  15, 48'h0000_1000_0F00};
    vecs[1] = '{48'h0000_1000_0000, 32'h4000, 17'h1000, 9'd16, 5, 0, 0, 80,   1280, 64, 48'h0000_1000_0000};
    vecs[2] = '{48'h0000_1000_0000, 32'h4000, 17'h1000, 9'd16, 4, 0, 1, 64,   1024, 63, 48'h0000_1000_3F00};
    vecs[3] = '{48'h0002_0000_0040, 32'h0100, 17'h0020, 9'd1,  1, 0, 0, 2,    2,    1,  48'h0002_0000_0050};
    vecs[4] = '{48'h0000_0000_3000, 32'h0300, 17'h0100, 9'd16, 4, 1, 0, 4,    64,   3,  48'h0000_0000_3000};
    vecs[5] = '{48'h0000_0000_8000, 32'h0100, 17'h0080, 9'd4,  3, 1, 1, 6,    24,   4,  48'h0000_0000_8000};

    // reset state
    step();
    check("rst_state", read_state, 3'd0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tick", tick, 1'b0);
    check("rst_read_error", read_error, 1'b0);
    check("rst_packet_count", packet_count, 32'd0);
    check("rst_araddr", araddr, 48'h0000_1000_0000);
    check("rst_arlen", arlen, 8'd15);

    // table-driven packet runs
    for (int i = 0; i < 6; i++) begin
      setup(vecs[i].base, vecs[i].size, vecs[i].pkt, vecs[i].burst);
      tog = vecs[i].tog;
      slow = vecs[i].slow;
      check_idx = vecs[i].chk_idx;
      check_addr = vecs[i].chk_addr;
      avail = vecs[i].npk;
      read_enable = 1;
      wait_ticks(vecs[i].npk, 20000, "vec_ticks");
      wait_state(3'd1, 50, "vec_back_to_wait");
      step();
      check("vec_ar_count", ar_cnt, vecs[i].exp_ars);
      check("vec_beat_count", beat_cnt, vecs[i].exp_beats);
      check("vec_tlast_count", tlast_cnt, vecs[i].npk);
      check("vec_packet_count", packet_count, vecs[i].npk);
      check("vec_hold_no_arvalid", arvalid, 1'b0);
      read_enable = 0;
      wait_state(3'd0, 10, "vec_to_idle");
      step();
      check("vec_idle_count_clear", packet_count, 32'd0);
    end

    // buffer_empty holds the FSM in WAIT, then AR follows promptly
    begin
      int bad = 0;
      int k = 0;
      setup(48'h5000, 32'h400, 17'h100, 9'd16);
      read_enable = 1;
      wait_state(3'd1, 10, "empty_enter_wait");
      for (int c = 0; c < 100; c++) begin
        step();
        if (read_state != 3'd1 || arvalid) bad++;
      end
      check("empty_hold_violations", bad, 0);
      avail = 1;
      while (buffer_empty && k < 5) begin step(); k++; end
      k = 0;
      while (!arvalid && k < 5) begin step(); k++; end
      check("empty_release_ar_latency_ok", (k >= 1 && k <= 2), 1'b1);
      wait_ticks(1, 2000, "empty_pkt_tick");
    end

    // error response on the 5th beat: burst completes, no tick, back to IDLE
    begin
      int k = 0;
      setup(48'h4000, 32'h1000, 17'h100, 9'd8);
      err_at = 4;
      avail = 1;
      read_enable = 1;
      while (!read_error && k < 200) begin step(); k++; end
      check("err_seen", read_error, 1'b1);
      check("err_still_in_r", read_state, 3'd3);
      check("err_beats_at_flag", beat_cnt, 5);
      read_enable = 0;
      wait_state(3'd0, 50, "err_to_idle");
      step();
      check("err_ar_count", ar_cnt, 1);
      check("err_burst_finished", beat_cnt, 8);
      check("err_no_tick", tick_cnt, 0);
      step();
      check("err_cleared_in_idle", read_error, 1'b0);
    end

    // stale ack high on TICK entry must not count as an acknowledge
    begin
      int seen = 0;
      setup(48'h5000, 32'h400, 17'h100, 9'd16);
      force_ack = 1;
      avail = 1;
      read_enable = 1;
      wait_state(3'd4, 200, "stale_enter_tick");
      for (int c = 0; c < 10; c++) begin
        step();
        if (tick) seen++;
      end
      check("stale_no_tick", seen, 0);
      check("stale_still_tick_state", read_state, 3'd4);
      force_ack = 0;
      wait_ticks(1, 20, "stale_tick_after_release");
      wait_state(3'd1, 20, "stale_back_to_wait");
      check("stale_packet_count", packet_count, 32'd1);
    end

    // read_enable dropped mid-packet: packet finishes through TICK, then IDLE
    begin
      int k = 0;
      setup(48'h7000, 32'h2000, 17'h1000, 9'd16);
      avail = 5;
      read_enable = 1;
      while (ar_cnt < 3 && k < 500) begin step(); k++; end
      read_enable = 0;
      wait_state(3'd0, 2000, "ren_off_to_idle");
      step();
      check("ren_off_ar_count", ar_cnt, 16);
      check("ren_off_beats", beat_cnt, 256);
      check("ren_off_tick", tick_cnt, 1);
      check("ren_off_count_cleared", packet_count, 32'd0);
    end

    // asynchronous reset in the middle of a read burst
    begin
      setup(48'h6000, 32'h800, 17'h100, 9'd16);
      avail = 2;
      read_enable = 1;
      wait_ticks(1, 500, "arst_first_tick");
      wait_state(3'd3, 50, "arst_in_r");
      step();
      step();
      check("arst_pre_count", packet_count, 32'd1);
      check("arst_pre_araddr", araddr, 48'h6100);
      #1;
      aresetn = 0;
      #1;
      check("arst_state", read_state, 3'd0);
      check("arst_arvalid", arvalid, 1'b0);
      check("arst_rready", rready, 1'b0);
      check("arst_tvalid", tvalid, 1'b0);
      check("arst_tlast", tlast, 1'b0);
      check("arst_tick", tick, 1'b0);
      check("arst_error", read_error, 1'b0);
      check("arst_count", packet_count, 32'd0);
      check("arst_araddr", araddr, 48'h6000);
      check("arst_read_address", read_address, 32'h6000);
      read_enable = 0;
      step();
      aresetn = 1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_readback_dmac.md
Name: rx_readback_dmac

Overview:
Downstream companion of the RX write DMA. Reads finished packets out of the DDR ring buffer over an AXI4 master read channel and streams them to the USB/host interface as 128-bit AXI-Stream. After each packet it strobes buffer_packet_tick so the write DMA frees that space from its occupation count. It waits on buffer_empty and never reads a partially written packet.

Parameters:
ADDR_W, 48, AXI address width
DATA_W, 128, AXI/stream data width; fixed 16 bytes per beat

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
read_enable  in  1  keep loop running while set
buffer_base_address  in  48  ring base in DDR
buffer_size  in  32  ring size in bytes; integer multiple of packet size
buffer_packet_size_bytes  in  17  bytes per packet; integer multiple of burst bytes
burst_length_set  in  9  beats per burst, 1..256
buffer_empty  in  1  from write DMA; 1 means less than one packet stored
buffer_packet_tick  out  1  packet-consumed strobe to write DMA
buffer_packet_tick_ack  in  1  ack from write DMA, level
read_state  out  3  FSM state
read_error  out  1  sticky, set on SLVERR/DECERR
packet_count  out  32  packets delivered since leaving IDLE
read_address  out  32  low 32 bits of current burst address
m_axi_araddr  out  48  read address
m_axi_arlen  out  8  burst_length_set-1
m_axi_arvalid  out  1
m_axi_arready  in  1
m_axi_rdata  in  128
m_axi_rresp  in  2
m_axi_rlast  in  1
m_axi_rvalid  in  1
m_axi_rready  out  1
m_axis_tx_tdata  out  128
m_axis_tx_tvalid  out  1
m_axis_tx_tready  in  1
m_axis_tx_tlast  out  1  last beat of packet

Behaviour:
- Reset is asynchronous on aresetn low. All registered outputs go to 0, m_axi_araddr goes to buffer_base_address, FSM goes to 0. Reset mid-burst abandons the AXI transaction; the bench resets the slave too.
- Derived values:
  - burst_bytes = burst_length_set*16.
  - bursts_per_packet = buffer_packet_size_bytes / burst_bytes, held in a register latched when leaving state 0.
- FSM:
  - 0 IDLE: burst/packet counters clear and the address reloads to base. read_error clears. packet_count clears only while read_enable=0. read_enable=1 -> 1.
  - 1 WAIT: no request is issued. buffer_empty=0 and read_enable=1 -> 2. read_enable=0 -> 0.
  - 2 AR: arvalid=1 and is held with stable araddr until arready. On the arready handshake, arvalid drops next cycle and the state goes to 3.
  - 3 R:
    - rready=tx_tready, tx_tvalid=rvalid, tx_tdata=rdata (combinational pass-through, zero latency).
    - tx_tlast=rlast AND (burst counter == bursts_per_packet-1).
    - A beat transfers when rvalid & tx_tready.
    - Any transferred beat with rresp[1]=1 sets read_error.
    - On a transferred rlast beat, the address advances by burst_bytes. Wrap: if the new address >= base+buffer_size, the address becomes base.
    - Then: read_error set -> 0, with no tick. Burst counter < bursts_per_packet-1 -> increment the counter and go to 2. Otherwise clear the counter and go to 4.
  - 4 TICK:
    - buffer_packet_tick=1 until buffer_packet_tick_ack=1, then tick=0.
    - Then wait for ack=0. That cycle increments packet_count.
    - Exit: read_enable=1 -> 1, else -> 0.
- Outside state 3, rready=0 and tx_tvalid=0.
- read_enable deasserted mid-packet: the current packet completes through TICK, then the FSM goes to IDLE.
- Ack already high on entering 4 (stale) is treated as not yet acknowledged. Wait for ack=0 first, then raise tick.
- One outstanding AR only; no address issued before the previous burst's rlast.
- m_axi_arlen = burst_length_set-1, truncated to 8 bits.
- Address arithmetic is 48-bit; read_address = araddr[31:0].
- Unused states 5–7 -> 0 next cycle with all outputs cleared.

Test Plan:
- Base 0x1000_0000, size 0x4000, packet 0x1000, burst 16 (256 B), buffer_empty=0 -> 16 AR bursts at +0x100 steps, 256 stream beats, tlast only on beat 256, one tick, packet_count=1.
- Four packets back-to-back -> the fifth packet's first araddr wraps to 0x1000_0000. The wrap triggers only on >= base+size, never earlier.
- Burst 1, packet 0x20 -> arlen=0, 2 bursts, tlast on the 2nd beat, rlast on every beat.
- buffer_empty=1 for 100 cycles then 0 -> FSM holds in 1 with arvalid=0, then issues AR within 2 cycles.
- tx_tready toggles 1/0 every cycle -> rready mirrors it, no beat lost or duplicated (bench compares against a data scoreboard).
- rresp=2'b10 on beat 5 -> read_error=1, burst finishes, FSM returns to 0, no tick.
- aresetn low during state 3 -> all outputs 0 asynchronously, araddr=base.
